// File: rtl/ysyx_2022040010_div_pkg.sv
// Shared types and constants for the iterative RV64M divider.
// Holds the FSM encoding, datapath and iteration widths, and the funct3 decode.
// Also holds a two's-complement helper used for operand and result sign fix-up.
package ysyx_2022040010_div_pkg;

  localparam int DIV_XLEN  = 64;
  localparam int DIV_CNT_W = 7;

  // Trial subtractions per operation for full-width and word ops
  localparam int ITER_D = 64;
  localparam int ITER_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // funct3 encodings of the M-extension divide/remainder group
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Returns {is_signed, is_rem} for a divide-group funct3
  function automatic logic [1:0] f3_decode(input logic [2:0] f3);
    logic [1:0] r;
    r = 2'b00;
    case (f3)
      F3_DIV:  r = 2'b10;
      F3_DIVU: r = 2'b00;
      F3_REM:  r = 2'b11;
      F3_REMU: r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/ysyx_2022040010_div_add.sv
// 64-bit ripple-carry adder: out_sum = in_a + in_b + in_c, carry-out on out_c.
// Combinational, zero latency.
// No handshake; alu_32 sign-extends bit 31 of the sum into the upper half.
module ysyx_2022040010_add (
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        in_c,
  input  logic        alu_32,
  output logic [63:0] out_sum,
  output logic        out_c
);

  logic [63:0] sum;
  logic [64:0] carry;

  // Bit-serial carry chain
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = in_c;
    for (int i = 0; i < 64; i++) begin
      sum[i]       = in_a[i] ^ in_b[i] ^ carry[i];
      carry[i + 1] = (in_a[i] & in_b[i]) | (carry[i] & (in_a[i] ^ in_b[i]));
    end
  end

  // Optional 32-bit result form
  always_comb begin
    out_sum = alu_32 ? {{32{sum[31]}}, sum[31:0]} : sum;
    out_c   = carry[64];
  end

endmodule

// File: rtl/ysyx_2022040010_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Latency accept->out_valid: 65 cycles (64-bit), 33 (word), 1 (divide-by-zero/overflow).
// in_ready only in IDLE; result held stable in DONE until out_ready; flush aborts.
module ysyx_2022040010_div
  import ysyx_2022040010_div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  div_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] abs_b;
  logic            neg_q;
  logic            neg_r;
  logic            rem_sel;
  logic            word_sel;

  logic [XLEN-1:0] a_ext, b_ext, abs_a_v, abs_b_v;
  logic            sign_a, sign_b, div_zero, ovf;

  // Operand extension, magnitudes and special-case detection at accept
  always_comb begin
    a_ext    = in_a;
    b_ext    = in_b;
    if (is_word) begin
      a_ext = is_signed ? {{32{in_a[31]}}, in_a[31:0]} : {32'b0, in_a[31:0]};
      b_ext = is_signed ? {{32{in_b[31]}}, in_b[31:0]} : {32'b0, in_b[31:0]};
    end
    sign_a   = is_signed & a_ext[XLEN-1];
    sign_b   = is_signed & b_ext[XLEN-1];
    abs_a_v  = sign_a ? neg64(a_ext) : a_ext;
    abs_b_v  = sign_b ? neg64(b_ext) : b_ext;
    div_zero = (b_ext == '0);
    if (is_word)
      ovf = is_signed & (in_a[31:0] == 32'h8000_0000) & (in_b[31:0] == 32'hFFFF_FFFF);
    else
      ovf = is_signed & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (in_b == '1);
  end

  logic [XLEN-1:0] rem_sh, trial;
  logic            trial_c, qbit;

  // Shifted partial remainder; the bit shifted out of the top feeds the quotient decision
  always_comb begin
    rem_sh = {rem[XLEN-2:0], quo[XLEN-1]};
  end

  ysyx_2022040010_add u_add (
    .in_a    (rem_sh),
    .in_b    (~abs_b),
    .in_c    (1'b1),
    .alu_32  (1'b0),
    .out_sum (trial),
    .out_c   (trial_c)
  );

  // A set top bit means the 65-bit shifted remainder exceeds any 64-bit divisor,
  // so the subtraction succeeds and the 64-bit difference is still exact.
  always_comb begin
    qbit = trial_c | rem[XLEN-1];
  end

  logic [XLEN-1:0] q_fix, r_fix, pick, result_nxt;

  // Sign correction, quotient/remainder select and word sign-extension
  always_comb begin
    q_fix      = neg_q ? neg64(quo) : quo;
    r_fix      = neg_r ? neg64(rem) : rem;
    pick       = rem_sel ? r_fix : q_fix;
    result_nxt = word_sel ? {{32{pick[31]}}, pick[31:0]} : pick;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      abs_b      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      rem_sel    <= 1'b0;
      word_sel   <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            rem_sel  <= is_rem;
            word_sel <= is_word;
            if (div_zero) begin
              quo   <= '1;
              rem   <= a_ext;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_DONE;
            end else if (ovf) begin
              quo   <= a_ext;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_DONE;
            end else begin
              rem   <= '0;
              // Word dividends start in the upper half so 32 shifts consume them
              quo   <= is_word ? {abs_a_v[31:0], 32'b0} : abs_a_v;
              abs_b <= abs_b_v;
              neg_q <= sign_a ^ sign_b;
              neg_r <= sign_a;
              cnt   <= is_word ? CNT_W'(ITER_W) : CNT_W'(ITER_D);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem <= qbit ? trial : rem_sh;
          quo <= {quo[XLEN-2:0], qbit};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle registers the corrected result; then wait for the consumer
          if (!out_valid) begin
            out_result <= result_nxt;
            out_valid  <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_div.sv
// Directed bench for the iterative divider: results, latency, special cases,
// backpressure, flush and asynchronous reset mid-operation.
module tb_ysyx_2022040010_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        is_signed = 1'b0;
  logic        is_rem = 1'b0;
  logic        is_word = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_2022040010_div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .is_signed  (is_signed),
    .is_rem     (is_rem),
    .is_word    (is_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Present one operation for a single cycle and let it be accepted
  task automatic launch(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic r, input logic w);
    @(negedge clk);
    chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    in_a = a; in_b = b; is_signed = s; is_rem = r; is_word = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid rises (bounded)
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic r, input logic w,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    launch(tag, a, b, s, r, w);
    wait_valid(tag, lat);
    chk({tag, "_result"}, out_result, exp);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    chk({tag, "_released"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_idle_ready"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    int   lat;
    logic seen;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Main function
    run_op("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 65);
    run_op("remu_100_7", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2, 65);
    run_op("div_m20_3", -64'sd20, 64'd3, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    run_op("rem_m20_3", -64'sd20, 64'd3, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("rem_7_m2", 64'd7, -64'sd2, 1'b1, 1'b1, 1'b0, 64'd1, 65);
    run_op("div_7_m2", 64'd7, -64'sd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("divu_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 64'd1, 65);
    run_op("remu_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFE, 65);
    run_op("divw", 64'h0000_0000_8000_0001, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_C000_0001, 33);
    run_op("divuw_ffff", 64'hABCD_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("remw_m7_2", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Special cases
    run_op("divu_by0", 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem_by0", 64'd5, 64'd0, 1'b1, 1'b1, 1'b0, 64'd5, 1);
    run_op("divuw_by0", 64'h1_0000_0009, 64'd0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remuw_by0", 64'h0000_0000_8000_0003, 64'h1_0000_0000, 1'b0, 1'b1, 1'b1,
           64'hFFFF_FFFF_8000_0003, 1);
    run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1);
    run_op("remw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 64'd0, 1);
    run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1,
           64'hFFFF_FFFF_8000_0000, 1);

    // Backpressure: result held for 10 cycles, in_valid ignored while busy
    out_ready = 1'b0;
    launch("bp", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    wait_valid("bp", lat);
    chk("bp_result", out_result, 64'd14);
    @(negedge clk);
    in_a = 64'd1; in_b = 64'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_hold_result", out_result, 64'd14);
      chk("bp_hold_in_ready", {63'b0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_transfer", {63'b0, out_valid}, 64'd0);
    chk("bp_idle_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("bp_no_stray_accept", {63'b0, in_ready}, 64'd1);

    // Flush at CALC cycle 20
    launch("fl", 64'd1000, 64'd10, 1'b0, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("fl_idle_ready", {63'b0, in_ready}, 64'd1);
    chk("fl_out_valid", {63'b0, out_valid}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1 seen = seen | out_valid;
    end
    chk("fl_no_result", {63'b0, seen}, 64'd0);

    // Flush wins over in_valid in the same cycle
    @(negedge clk);
    in_a = 64'd8; in_b = 64'd2; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flp_not_accepted", {63'b0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1 seen = seen | out_valid;
    end
    chk("flp_no_result", {63'b0, seen}, 64'd0);

    // Asynchronous reset mid-CALC; out_result currently holds an earlier nonzero value
    launch("rs", 64'd12345, 64'd7, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rs_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rs_out_result", out_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_9_3", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, 65);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
